alarm_annunciator: RTL and testbench
====================================

ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 The block SHALL have parameter TONE_HALF, default 4, giving the clocks per buzzer tone half-period (legal 1..255).
REQ-002 The block SHALL have parameter BEEP_ON_TICKS, default 3, giving the ticks per audible beep phase (legal 1..255).
REQ-003 The block SHALL have parameter BEEP_OFF_TICKS, default 2, giving the ticks per silent gap (legal 1..255).
REQ-004 The block SHALL have parameter SNOOZE_TICKS, default 8, giving the ticks per snooze interval (legal 1..255).
REQ-005 The block SHALL have parameter MAX_SNOOZE, default 3, giving the snoozes allowed per alert episode (legal 0..15).
REQ-006 The block SHALL have parameter ESC_BEEPS, default 5, giving the beeps before escalation; it is used only when the escalation macro is defined.
REQ-007 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 Port rst_n: input, 1 bit, asynchronous active-high reset (1 = reset), despite the name.
REQ-009 Port alert: input, 1 bit, level from the upstream alarm FSM; 1 = alarm ringing.
REQ-010 Port ack: input, 1 bit, single-cycle active-high press pulse from a debounced button.
REQ-011 Port tick: input, 1 bit, single-cycle timebase enable.
REQ-012 Port buzzer: output, 1 bit, registered square-wave tone drive.
REQ-013 Port led: output, 1 bit, registered; 1 whenever state is not OFF.
REQ-014 Port snoozing: output, 1 bit, registered; 1 in SNOOZE only.
REQ-015 Port beep_cnt: output, 8 bits, registered count of completed beeps in the current episode.
REQ-016 Port snooze_cnt: output, 4 bits, registered count of snoozes taken in the current episode.

Function
REQ-017 The FSM SHALL have states OFF, BEEP_ON, BEEP_OFF, SNOOZE and, only with the macro, CONT.
- OFF -> BEEP_ON on the edge sampling alert=1.
- BEEP_ON -> BEEP_OFF on the edge sampling the BEEP_ON_TICKS-th tick since entry; beep_cnt+1 on the same edge, saturating at 255.
- BEEP_OFF -> BEEP_ON on the BEEP_OFF_TICKS-th tick since entry.
- SNOOZE -> BEEP_ON on the SNOOZE_TICKS-th tick since entry.
REQ-018 Priority SHALL be: alert=0 first, then ack, then tick expiry.
- alert=0 in any state -> OFF next edge; beep_cnt and snooze_cnt cleared on that edge.
REQ-019 Ack handling:
- ack=1 in BEEP_ON, BEEP_OFF or CONT with snooze_cnt < MAX_SNOOZE -> SNOOZE next edge; snooze_cnt+1; tick counter cleared.
- Otherwise ack is ignored, including ack in OFF or SNOOZE.
REQ-020 The tick counter SHALL clear on every state entry and count only sampled ticks.
- A tick coincident with a state transition is not counted in the new state.
REQ-021 Buzzer behaviour:
- buzzer SHALL be 1 in the first cycle of BEEP_ON or CONT.
- It toggles every TONE_HALF clocks while in those states.
- It is 0 in all other states.
- The tone divider restarts on each entry.
REQ-022 All outputs SHALL be registered and SHALL reflect the new state in the cycle after the transition edge; latency from alert rising to buzzer=1 is exactly 1 clock.

Reset
REQ-023 While rst_n=1, the block SHALL hold the following asynchronously, independent of clk:
- state=OFF; buzzer, led, snoozing = 0.
- beep_cnt, snooze_cnt = 0.
- tick counter and tone divider = 0.
REQ-024 On the first edge after rst_n falls with alert=1, the block SHALL enter BEEP_ON; a reset mid-episode discards all history.

Configuration
REQ-025 With ALARM_ANNUNCIATOR_ESCALATE_EN defined, BEEP_OFF SHALL go to CONT instead of BEEP_ON once beep_cnt equals ESC_BEEPS.
- CONT is a continuous tone with led=1.
- CONT is left only by alert=0 or an accepted ack.
REQ-026 Without the macro, the CONT state and ESC_BEEPS logic SHALL be absent, and beeping SHALL cycle indefinitely.

Verification
REQ-027 Reset, alert=0 held 20 clk, pulse rst_n=1 mid-stream -> all outputs 0 immediately, with no clock needed.
REQ-028 Defaults, tick every 4 clk, alert=1 from cycle 0, no ack -> buzzer pattern:
- buzzer=1 at cycle 1, then 1111000011110000... for 12 clk.
- Then silent for 8 clk; beep_cnt=1 at the BEEP_OFF entry.
REQ-029 Ack during BEEP_ON -> next cycle snoozing=1, buzzer=0, snooze_cnt=1; buzzer resumes after exactly 8 ticks (32 clk).
REQ-030 Three accepted acks -> snooze_cnt=3; a fourth ack is ignored and beeping continues.
REQ-031 alert=0 during SNOOZE with a coincident ack and tick -> OFF next edge; beep_cnt=0, snooze_cnt=0.
REQ-032 With the macro, no ack -> after 5 beeps, CONT with buzzer toggling every 4 clk continuously; without the macro -> a 6th BEEP_ON/BEEP_OFF cycle occurs and beep_cnt reaches 6.

Source files
------------

// File: rtl/alarm_annunciator.sv
// ---------------------------------------------------------------------------
// alarm_annunciator
//
// Turns the "alarm ringing" level from the upstream alarm FSM into a beeping
// buzzer pattern with a snooze button. While alert is high the block
// alternates audible beeps and silent gaps. Each phase length is counted in
// timebase ticks. An ack press starts a snooze interval, and only a limited
// number of snoozes is allowed per alert episode. Dropping alert silences
// everything and clears the episode counters.
//
// Optional feature (macro ALARM_ANNUNCIATOR_ESCALATE_EN):
//   After ESC_BEEPS completed beeps, the end of the silent gap enters CONT.
//   CONT is a continuous tone that only alert=0 or an accepted ack can leave.
//   Without the macro, beeping cycles indefinitely and ESC_BEEPS is unused.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : asynchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   alert      : 1 = alarm ringing (level)
//   ack        : single-cycle press pulse (debounced)
//   tick       : single-cycle timebase enable
//   buzzer     : registered square-wave tone drive
//   led        : registered, 1 whenever the state is not OFF
//   snoozing   : registered, 1 in SNOOZE only
//   beep_cnt   : registered count of completed beeps this episode (saturates)
//   snooze_cnt : registered count of snoozes taken this episode
// ---------------------------------------------------------------------------
module alarm_annunciator #(
  parameter int unsigned TONE_HALF      = 4,
  parameter int unsigned BEEP_ON_TICKS  = 3,
  parameter int unsigned BEEP_OFF_TICKS = 2,
  parameter int unsigned SNOOZE_TICKS   = 8,
  parameter int unsigned MAX_SNOOZE     = 3,
  parameter int unsigned ESC_BEEPS      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alert,
  input  logic       ack,
  input  logic       tick,
  output logic       buzzer,
  output logic       led,
  output logic       snoozing,
  output logic [7:0] beep_cnt,
  output logic [3:0] snooze_cnt
);

  // Elaboration-time range checks on the parameters.
  if (TONE_HALF < 1 || TONE_HALF > 255 || BEEP_ON_TICKS < 1 || BEEP_ON_TICKS > 255 ||
      BEEP_OFF_TICKS < 1 || BEEP_OFF_TICKS > 255 || SNOOZE_TICKS < 1 ||
      SNOOZE_TICKS > 255 || MAX_SNOOZE > 15 || ESC_BEEPS > 255) begin : g_bad_param
    $error("alarm_annunciator: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    ST_OFF,
    ST_BEEP_ON,
    ST_BEEP_OFF,
    ST_SNOOZE
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
    , ST_CONT
`endif
  } state_t;

  // Each phase expires on the tick that arrives while the counter already
  // holds (N-1), i.e. on the N-th tick since entry.
  localparam logic [7:0] TONE_LAST   = 8'(TONE_HALF - 1);
  localparam logic [7:0] ON_LAST     = 8'(BEEP_ON_TICKS - 1);
  localparam logic [7:0] OFF_LAST    = 8'(BEEP_OFF_TICKS - 1);
  localparam logic [7:0] SNZ_LAST    = 8'(SNOOZE_TICKS - 1);
  localparam logic [3:0] SNOOZE_LIM  = 4'(MAX_SNOOZE);
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
  localparam logic [7:0] ESC_LIMIT   = 8'(ESC_BEEPS);
`endif

  state_t     state_q,      state_d;
  logic [7:0] tick_cnt_q,   tick_cnt_d;
  logic [7:0] tone_cnt_q,   tone_cnt_d;
  logic       buzzer_q,     buzzer_d;
  logic       led_q,        led_d;
  logic       snoozing_q,   snoozing_d;
  logic [7:0] beep_cnt_q,   beep_cnt_d;
  logic [3:0] snooze_cnt_q, snooze_cnt_d;

  logic ack_ok;
  logic entering;
  logic tone_on;

  // Next state and episode counters. alert=0 wins, then an accepted ack,
  // then tick expiry.
  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    beep_cnt_d   = beep_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    ack_ok       = 1'b0;

    case (state_q)
      ST_BEEP_ON, ST_BEEP_OFF: ack_ok = (snooze_cnt_q < SNOOZE_LIM);
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
      ST_CONT:                 ack_ok = (snooze_cnt_q < SNOOZE_LIM);
`endif
      default:                 ack_ok = 1'b0;
    endcase

    if (!alert) begin
      state_d      = ST_OFF;
      beep_cnt_d   = 8'd0;
      snooze_cnt_d = 4'd0;
    end else if (ack && ack_ok) begin
      state_d      = ST_SNOOZE;
      snooze_cnt_d = snooze_cnt_q + 4'd1;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_BEEP_ON;
        ST_BEEP_ON: begin
          if (tick && tick_cnt_q == ON_LAST) begin
            state_d = ST_BEEP_OFF;
            if (beep_cnt_q != 8'hFF) beep_cnt_d = beep_cnt_q + 8'd1;
          end
        end
        ST_BEEP_OFF: begin
          if (tick && tick_cnt_q == OFF_LAST) begin
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
            state_d = (beep_cnt_q == ESC_LIMIT) ? ST_CONT : ST_BEEP_ON;
`else
            state_d = ST_BEEP_ON;
`endif
          end
        end
        ST_SNOOZE: begin
          if (tick && tick_cnt_q == SNZ_LAST) state_d = ST_BEEP_ON;
        end
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
        ST_CONT: state_d = ST_CONT;
`endif
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Tick counter, tone divider and registered outputs, all derived from the
  // next state so the outputs reflect the new state one cycle after the edge.
  // There are no self-transitions, so a change of state marks a fresh entry.
  always_comb begin
    entering   = (state_d != state_q);
    tick_cnt_d = tick_cnt_q;
    tone_cnt_d = 8'd0;
    buzzer_d   = 1'b0;
    tone_on    = (state_d == ST_BEEP_ON);
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
    tone_on    = tone_on || (state_d == ST_CONT);
`endif

    if (entering || state_d == ST_OFF) begin
      tick_cnt_d = 8'd0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 8'd1;
    end

    if (tone_on) begin
      if (entering) begin
        buzzer_d   = 1'b1;
        tone_cnt_d = 8'd0;
      end else if (tone_cnt_q == TONE_LAST) begin
        buzzer_d   = ~buzzer_q;
        tone_cnt_d = 8'd0;
      end else begin
        buzzer_d   = buzzer_q;
        tone_cnt_d = tone_cnt_q + 8'd1;
      end
    end

    led_d      = (state_d != ST_OFF);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  // NOTE: the reset input is active high, so the sensitivity is posedge rst_n
  // and the reset branch is taken while rst_n is 1.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_OFF;
      tick_cnt_q   <= 8'd0;
      tone_cnt_q   <= 8'd0;
      buzzer_q     <= 1'b0;
      led_q        <= 1'b0;
      snoozing_q   <= 1'b0;
      beep_cnt_q   <= 8'd0;
      snooze_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      tone_cnt_q   <= tone_cnt_d;
      buzzer_q     <= buzzer_d;
      led_q        <= led_d;
      snoozing_q   <= snoozing_d;
      beep_cnt_q   <= beep_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
    end
  end

  assign buzzer     = buzzer_q;
  assign led        = led_q;
  assign snoozing   = snoozing_q;
  assign beep_cnt   = beep_cnt_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// ---------------------------------------------------------------------------
// tb_alarm_annunciator
//
// Self-checking bench for alarm_annunciator with default parameters. Each
// scenario task drives alert/ack/tick one clock at a time. When it drives a
// cycle, it pushes the expected output word for that cycle onto a
// scoreboard queue. After the edge, it pops the word and compares it with
// the DUT outputs.
// Output word layout: {buzzer, led, snoozing, beep_cnt[7:0], snooze_cnt[3:0]}.
// ---------------------------------------------------------------------------
module tb_alarm_annunciator;

  logic       clk;
  logic       rst_n;
  logic       alert;
  logic       ack;
  logic       tick;
  logic       buzzer;
  logic       led;
  logic       snoozing;
  logic [7:0] beep_cnt;
  logic [3:0] snooze_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [14:0] exp_q[$];

  localparam logic [14:0] ZERO = 15'd0;

  alarm_annunciator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alert      (alert),
    .ack        (ack),
    .tick       (tick),
    .buzzer     (buzzer),
    .led        (led),
    .snoozing   (snoozing),
    .beep_cnt   (beep_cnt),
    .snooze_cnt (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic b, input logic l, input logic s,
                                     input logic [7:0] bc, input logic [3:0] sc);
    return {b, l, s, bc, sc};
  endfunction

  function automatic logic [14:0] obs();
    return {buzzer, led, snoozing, beep_cnt, snooze_cnt};
  endfunction

  // Apply inputs for one cycle, queue that cycle's expected outputs, and
  // advance to just after the edge.
  task automatic drive(input logic a, input logic k, input logic t, input logic [14:0] want);
    alert = a;
    ack   = k;
    tick  = t;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] got, want;
    rst_n = 1'b1; alert = 1'b0; ack = 1'b0; tick = 1'b0;
    exp_q.push_back(ZERO);
    @(posedge clk); #1;
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL reset_hold: got %b want %b", got, want); end

    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, ZERO);
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL idle[%0d]: got %b want %b", i, got, want); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, pk(1, 1, 0, 8'd0, 4'd0));
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL pre_rst[%0d]: got %b want %b", i, got, want); end
    end
    // Reset between edges: the outputs must clear with no clock edge.
    rst_n = 1'b1;
    exp_q.push_back(ZERO);
    #2;
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL async_rst: got %b want %b", got, want); end
    drive(1'b1, 1'b0, 1'b1, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL rst_held: got %b want %b", got, want); end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, pk(1, 1, 0, 8'd0, 4'd0));
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL rst_exit: got %b want %b", got, want); end
    drive(1'b0, 1'b0, 1'b0, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL rst_off: got %b want %b", got, want); end
  endtask

  // Tick every 4 clocks, no ack. Without the escalation macro there are 3 ticks
  // (12 clk) of beep and 2 ticks (8 clk) of gap, so each 20 clk period
  // completes one beep. With the macro, CONT follows after the 5th beep.
  task automatic test_beep_pattern();
    logic [14:0] got, want;
    int p;
    logic b;
    logic [7:0] bc;
    for (int c = 0; c < 120; c++) begin
      p  = c % 20;
      bc = 8'(c / 20 + ((p >= 12) ? 1 : 0));
      b  = (p < 12) && ((p / 4) % 2 == 0);
`ifdef ALARM_ANNUNCIATOR_ESCALATE_EN
      if (c >= 100) begin
        bc = 8'd5;
        b  = ((c - 100) / 4) % 2 == 0;
      end
`endif
      drive(1'b1, 1'b0, (c % 4) == 0, pk(b, 1, 0, bc, 4'd0));
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL beep[%0d]: got %b want %b", c, got, want); end
    end
    drive(1'b0, 1'b0, 1'b0, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL beep_end: got %b want %b", got, want); end
  endtask

  // Ack on a tick cycle in BEEP_ON. Eight further ticks (32 clk) later,
  // the tone restarts.
  task automatic test_snooze();
    logic [14:0] got, want;
    for (int e = 0; e < 44; e++) begin
      if (e < 4)       want = pk(1, 1, 0, 8'd0, 4'd0);
      else if (e < 36) want = pk(0, 1, 1, 8'd0, 4'd1);
      else if (e < 40) want = pk(1, 1, 0, 8'd0, 4'd1);
      else             want = pk(0, 1, 0, 8'd0, 4'd1);
      drive(1'b1, e == 4, (e % 4) == 0, want);
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL snooze[%0d]: got %b want %b", e, got, want); end
    end
    drive(1'b0, 1'b0, 1'b0, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL snooze_end: got %b want %b", got, want); end
  endtask

  // Tick every cycle. The acks at 1, 10 and 19 are accepted. The ack at 5
  // (in SNOOZE) is ignored. The acks at 28 and 31 exceed the snooze limit.
  task automatic test_max_snooze();
    logic [14:0] got, want;
    logic        k, s, b;
    logic [3:0]  sc;
    for (int e = 0; e < 34; e++) begin
      k  = (e == 1) || (e == 5) || (e == 10) || (e == 19) || (e == 28) || (e == 31);
      s  = (e >= 1 && e <= 8) || (e >= 10 && e <= 17) || (e >= 19 && e <= 26);
      sc = 4'((e >= 1) + (e >= 10) + (e >= 19));
      b  = !s && !(e == 30 || e == 31);
      drive(1'b1, k, 1'b1, pk(b, 1, s, (e >= 30) ? 8'd1 : 8'd0, sc));
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL max_snooze[%0d]: got %b want %b", e, got, want); end
    end
    drive(1'b0, 1'b0, 1'b0, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL max_snooze_end: got %b want %b", got, want); end
  endtask

  // Build some history, snooze, then drop alert on a cycle that also has
  // ack and tick.
  task automatic test_alert_drop();
    logic [14:0] got, want;
    logic [14:0] tbl[9];
    logic        a_v[9];
    logic        k_v[9];
    tbl[0] = pk(1, 1, 0, 8'd0, 4'd0); a_v[0] = 1; k_v[0] = 0;
    tbl[1] = pk(1, 1, 0, 8'd0, 4'd0); a_v[1] = 1; k_v[1] = 0;
    tbl[2] = pk(1, 1, 0, 8'd0, 4'd0); a_v[2] = 1; k_v[2] = 0;
    tbl[3] = pk(0, 1, 0, 8'd1, 4'd0); a_v[3] = 1; k_v[3] = 0;
    tbl[4] = pk(0, 1, 0, 8'd1, 4'd0); a_v[4] = 1; k_v[4] = 0;
    tbl[5] = pk(1, 1, 0, 8'd1, 4'd0); a_v[5] = 1; k_v[5] = 0;
    tbl[6] = pk(0, 1, 1, 8'd1, 4'd1); a_v[6] = 1; k_v[6] = 1;
    tbl[7] = ZERO;                    a_v[7] = 0; k_v[7] = 1;
    tbl[8] = ZERO;                    a_v[8] = 0; k_v[8] = 0;
    for (int e = 0; e < 9; e++) begin
      drive(a_v[e], k_v[e], 1'b1, tbl[e]);
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL alert_drop[%0d]: got %b want %b", e, got, want); end
    end
  endtask

  // Ack coinciding with the expiring BEEP_ON tick: ack wins, no beep counted.
  task automatic test_ack_priority();
    logic [14:0] got, want;
    for (int e = 0; e < 13; e++) begin
      if (e < 3)       want = pk(1, 1, 0, 8'd0, 4'd0);
      else if (e < 11) want = pk(0, 1, 1, 8'd0, 4'd1);
      else             want = pk(1, 1, 0, 8'd0, 4'd1);
      drive(1'b1, e == 3, 1'b1, want);
      got = obs(); want = exp_q.pop_front(); compared++;
      if (got !== want) begin mismatched++; $display("FAIL ack_prio[%0d]: got %b want %b", e, got, want); end
    end
    drive(1'b0, 1'b0, 1'b0, ZERO);
    got = obs(); want = exp_q.pop_front(); compared++;
    if (got !== want) begin mismatched++; $display("FAIL ack_prio_end: got %b want %b", got, want); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    alert = 1'b0;
    ack   = 1'b0;
    tick  = 1'b0;
    test_reset();
    test_beep_pattern();
    test_snooze();
    test_max_snooze();
    test_alert_drop();
    test_ack_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
